// File: rtl/pipe_hazard_ctrl.sv
// Pipeline buffer-register sequencing: load-use bubbles, redirect squash, dmem freeze, halt drain.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_halt,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_redirect,
    input  logic                  dmem_busy,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cyc,
    output logic [CNT_W-1:0]      perf_flush_evt
`endif
);

    localparam int unsigned DRAIN_W = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_next;
    logic                 lu;

    assign lu = ex_memread && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // Next state and stage controls; everything is forced low while reset is held.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        pc_en          = 1'b0;
        if_id_en       = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_en       = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_en      = 1'b0;
        mem_wb_en      = 1'b0;
        case (state)
            ST_RUN: begin
                if (dmem_busy) begin
                    // full freeze
                end else if (ex_redirect) begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    id_ex_en    = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (lu) begin
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                end else begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                    if (id_halt) begin
                        state_next     = ST_DRAIN;
                        drain_cnt_next = DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if_id_flush = 1'b1;
                if (!dmem_busy) begin
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                    if (drain_cnt == '0) state_next = ST_HALTED;
                    else                 drain_cnt_next = drain_cnt - DRAIN_W'(1);
                end
            end
            default: begin
                state_next = ST_HALTED;
            end
        endcase
        if (!rst_n) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b0;
            id_ex_en    = 1'b0;
            id_ex_flush = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            halted    <= (state_next == ST_HALTED);
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic stall_inc, flush_inc;

    assign stall_inc = (state == ST_RUN) && (lu || dmem_busy);
    assign flush_inc = (state == ST_RUN) && !dmem_busy && ex_redirect;

    // Saturating event counters; only RUN cycles can increment, so HALTED freezes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_evt <= '0;
        end else begin
            if (stall_inc && (perf_stall_cyc != '1)) perf_stall_cyc <= perf_stall_cyc + CNT_W'(1);
            if (flush_inc && (perf_flush_evt != '1)) perf_flush_evt <= perf_flush_evt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a reference model pushes expected controls per cycle,
// the negedge sampler pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

    localparam int unsigned RW = 5;
    localparam int unsigned DC = 3;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, id_halt, ex_memread, ex_redirect, dmem_busy;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [CW-1:0] perf_stall_cyc, perf_flush_evt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(RW), .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_halt(id_halt), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .dmem_busy(dmem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
        .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_evt(perf_flush_evt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int         m_state;   // 0 RUN, 1 DRAIN, 2 HALTED
    int         m_cnt;
    int         m_stall;
    int         m_flush;

    logic [7:0] got_vec;
    assign got_vec = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_lu();
        return ex_memread && (ex_rd != 0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    endfunction

    // Bit order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted
    function automatic logic [7:0] model_out();
        logic [7:0] v;
        if (m_state == 0) begin
            if (dmem_busy)        v = 8'h00;
            else if (ex_redirect) v = 8'hFE;
            else if (model_lu())  v = 8'h1E;
            else                  v = 8'hD6;
        end else if (m_state == 1) begin
            v = dmem_busy ? 8'h20 : 8'h36;
        end else begin
            v = 8'h01;
        end
        if (!rst_n) v = {7'h00, v[0] & (m_state == 2)};
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_advance();
        if (!rst_n) begin
            model_reset();
        end else if (m_state == 0) begin
            if (dmem_busy || model_lu()) m_stall++;
            if (!dmem_busy && ex_redirect) m_flush++;
            if (!dmem_busy && !ex_redirect && !model_lu() && id_halt) begin
                m_state = 1; m_cnt = DC - 1;
            end
        end else if (m_state == 1) begin
            if (!dmem_busy) begin
                if (m_cnt == 0) m_state = 2;
                else            m_cnt--;
            end
        end
    endtask

    task automatic compare_now(input string tag);
        exp_q.push_back(model_out());
        check_eq(tag, {24'h0, got_vec}, {24'h0, exp_q.pop_front()});
`ifdef PIPE_CTRL_PERF_EN
        check_eq({tag, "_stall"}, perf_stall_cyc, m_stall);
        check_eq({tag, "_flush"}, perf_flush_evt, m_flush);
`endif
    endtask

    // Inputs are already applied (posedge+1); queue expectation, compare at negedge, advance model.
    task automatic step(input string tag);
        exp_q.push_back(model_out());
        @(negedge clk);
        check_eq(tag, {24'h0, got_vec}, {24'h0, exp_q.pop_front()});
`ifdef PIPE_CTRL_PERF_EN
        check_eq({tag, "_stall"}, perf_stall_cyc, m_stall);
        check_eq({tag, "_flush"}, perf_flush_evt, m_flush);
`endif
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_in(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2, input logic u1,
                          input logic u2, input logic hlt, input logic mr, input logic [RW-1:0] rd,
                          input logic rdr, input logic bsy);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; id_halt = hlt;
        ex_memread = mr; ex_rd = rd; ex_redirect = rdr; dmem_busy = bsy;
    endtask

    task automatic set_idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        step("reset_hold");
        rst_n = 1'b1;
        step("idle_run");

        // load-use on rs1, then recovery
        set_in(5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step("lu_rs1");
        set_idle();
        step("lu_after");
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        step("lu_rd0");
        set_in(5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step("lu_nouse");
        set_in(5'd2, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        step("lu_rs2");
        set_in(5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
        step("no_memread");

        // redirect beats lu, dmem_busy beats both
        set_in(5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        step("lu_redirect");
        set_in(5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        step("lu_redir_busy");
        set_in(5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        step("halt_behind_lu");

        // halt drain with a 2-cycle dmem stall; id_* unknown and redirect ignored while draining
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        step("halt_enter");
        set_in('x, 'x, 1'bx, 1'bx, 1'bx, 1'b0, 5'd0, 1'b1, 1'b0);
        step("drain_1");
        dmem_busy = 1'b1;
        step("drain_busy_1");
        step("drain_busy_2");
        dmem_busy = 1'b0;
        step("drain_2");
        step("drain_3");
        step("halted_1");
        set_in(5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        step("halted_hold");

        // async reset while HALTED
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_now("rst_in_halted");
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_idle();
        step("run_after_rst1");

        // async reset while DRAIN
        id_halt = 1'b1;
        step("halt_enter_2");
        id_halt = 1'b0;
        step("drain_again");
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_now("rst_in_drain");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("run_after_rst2");

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0));
            rst_n = ($urandom_range(0, 29) != 0);
            if (!rst_n) model_reset();
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
